// File: rtl/carga_serial_red.sv
// Bit-serial operand loader and result capture stage for the iterative comparison network.
// Shifts in A/B MSB first, freezes them for one evaluation cycle, then holds Z until acknowledged.
module carga_serial_red #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         bit_valid,
    input  logic         a_bit,
    input  logic         b_bit,
    output logic         bit_ready,
    output logic [N-1:0] A,
    output logic [N-1:0] B,
    input  logic         Zin,
    output logic         Z,
    output logic         z_valid,
    input  logic         res_ack
);

    localparam int unsigned CW = (N > 2) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        RECV = 2'd0,
        EVAL = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [CW-1:0]   r_cnt;
    logic [N-1:0]    r_a;
    logic [N-1:0]    r_b;
    logic            r_z;
    logic            r_bit_ready;
    logic            r_z_valid;
    logic            w_accept;
    logic            w_last_bit;

    assign w_accept   = (r_state == RECV) && bit_valid;
    assign w_last_bit = (r_cnt == CW'(N - 1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RECV;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            RECV: begin
                if (w_accept && w_last_bit) begin
                    w_next_state = EVAL;
                end
            end
            EVAL: begin
                w_next_state = HOLD;
            end
            HOLD: begin
                if (res_ack) begin
                    w_next_state = RECV;
                end
            end
            default: begin
                w_next_state = RECV;
            end
        endcase
    end

    // Handshake flags are registered copies of the decode of the upcoming state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bit_ready <= 1'b1;
            r_z_valid   <= 1'b0;
        end else begin
            r_bit_ready <= (w_next_state == RECV);
            r_z_valid   <= (w_next_state == HOLD);
        end
    end

    // Operand shift registers and bit counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a   <= '0;
            r_b   <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_a   <= {r_a[N-2:0], a_bit};
            r_b   <= {r_b[N-2:0], b_bit};
            r_cnt <= w_last_bit ? '0 : r_cnt + CW'(1);
        end
    end

    // Network result is only meaningful once A/B have been stable for the EVAL cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_z <= 1'b0;
        end else if (r_state == EVAL) begin
            r_z <= Zin;
        end
    end

    assign A         = r_a;
    assign B         = r_b;
    assign Z         = r_z;
    assign bit_ready = r_bit_ready;
    assign z_valid   = r_z_valid;

endmodule
